// File: rtl/rat_maze_solver_if.sv
// Maze memory bus between the DFS solver (master) and the 1-bit-per-cell maze store (slave).
// D_out is combinational and answers the X/Y address in the same cycle as RD.
interface rat_maze_solver_if #(
  parameter int AW = 4
);
  logic [AW-1:0] X;
  logic [AW-1:0] Y;
  logic          D_out;
  logic          D_in;
  logic          RD;
  logic          WR;

  modport master (
    output X, Y, D_in, RD, WR,
    input  D_out
  );

  modport slave (
    input  X, Y, D_in, RD, WR,
    output D_out
  );
endinterface

// File: rtl/rat_maze_solver.sv
// Depth-first maze solver from (0,0) to (N-1,N-1); one cycle per CHECK/STEP/BACK, then replays moves on Run.
// No backpressure: the maze memory answers combinationally, and Start/Run are level requests.
module rat_maze_solver #(
  parameter int N     = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 256
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Start,
  input  logic                Run,
  output logic                Fail,
  output logic                Done,
  output logic [1:0]          Move,
  rat_maze_solver_if.master   mem
);
  localparam int SPW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CHECK, S_STEP, S_BACK, S_DONE, S_SHOW, S_FAIL
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [AW-1:0]  r_x, r_y, w_x_nxt, w_y_nxt;
  logic [1:0]     r_dir, w_dir_nxt;
  logic [SPW-1:0] r_sp, w_sp_nxt;
  logic [SPW-1:0] r_idx, w_idx_nxt;
  logic [1:0]     r_stack [DEPTH];
  logic           w_push;

  logic [AW-1:0]  w_nx, w_ny;
  logic           w_oob;
  logic [1:0]     w_top;

  // Neighbour of the current cell in the direction being tried.
  always_comb begin
    w_nx  = r_x;
    w_ny  = r_y;
    w_oob = 1'b0;
    case (r_dir)
      2'd0: begin w_oob = (r_y == '0);   w_ny = r_y - AW'(1); end
      2'd1: begin w_oob = (r_x == LAST); w_nx = r_x + AW'(1); end
      2'd2: begin w_oob = (r_x == '0);   w_nx = r_x - AW'(1); end
      default: begin w_oob = (r_y == LAST); w_ny = r_y + AW'(1); end
    endcase
  end

  assign w_top = r_stack[r_sp - SPW'(1)];

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dir_nxt   = r_dir;
    w_sp_nxt    = r_sp;
    w_idx_nxt   = r_idx;
    w_push      = 1'b0;
    mem.X       = r_x;
    mem.Y       = r_y;
    mem.RD      = 1'b0;
    mem.WR      = 1'b0;
    mem.D_in    = 1'b0;
    Done        = 1'b0;
    Fail        = 1'b0;
    Move        = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_nxt = S_INIT;
      end
      S_INIT: begin
        mem.WR      = 1'b1;
        mem.D_in    = 1'b1;
        mem.X       = '0;
        mem.Y       = '0;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
        w_sp_nxt    = '0;
        w_dir_nxt   = 2'd0;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!w_oob) begin
          mem.RD = 1'b1;
          mem.X  = w_nx;
          mem.Y  = w_ny;
        end
        if (w_oob || mem.D_out) begin
          if (r_dir == 2'd3) w_state_nxt = S_BACK;
          else               w_dir_nxt   = r_dir + 2'd1;
        end else begin
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        mem.WR   = 1'b1;
        mem.D_in = 1'b1;
        mem.X    = w_nx;
        mem.Y    = w_ny;
        w_push   = 1'b1;
        w_sp_nxt = r_sp + SPW'(1);
        w_x_nxt  = w_nx;
        w_y_nxt  = w_ny;
        if (w_nx == LAST && w_ny == LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_dir_nxt   = 2'd0;
          w_state_nxt = S_CHECK;
        end
      end
      S_BACK: begin
        if (r_sp == '0) begin
          w_state_nxt = S_FAIL;
        end else begin
          w_sp_nxt = r_sp - SPW'(1);
          case (w_top)
            2'd0:    w_y_nxt = r_y + AW'(1);
            2'd1:    w_x_nxt = r_x - AW'(1);
            2'd2:    w_x_nxt = r_x + AW'(1);
            default: w_y_nxt = r_y - AW'(1);
          endcase
          // A popped "down" means the parent has exhausted every direction too.
          if (w_top != 2'd3) begin
            w_dir_nxt   = w_top + 2'd1;
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_DONE: begin
        Done = 1'b1;
        if (Run) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_SHOW;
        end
      end
      S_SHOW: begin
        Done      = 1'b1;
        Move      = r_stack[r_idx];
        w_idx_nxt = r_idx + SPW'(1);
        if (r_idx == r_sp - SPW'(1)) w_state_nxt = S_DONE;
      end
      S_FAIL: begin
        Fail = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_dir   <= 2'd0;
      r_sp    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_dir   <= w_dir_nxt;
      r_sp    <= w_sp_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_stack[r_sp] <= r_dir;
  end
endmodule

// File: tb/tb_rat_maze_solver.sv
// Directed bench for rat_maze_solver with a behavioural 16x16 maze memory and bus monitor.
module tb_rat_maze_solver;
  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic       Run;
  logic       Fail;
  logic       Done;
  logic [1:0] Move;

  logic [255:0] mem;
  int           wr_cnt;
  int           bus_err;
  int           errors;
  int           checks;
  logic [1:0]   exp_q[$];

  rat_maze_solver_if #(.AW(4)) mif ();

  rat_maze_solver #(.N(16), .AW(4), .DEPTH(256)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .Run   (Run),
    .Fail  (Fail),
    .Done  (Done),
    .Move  (Move),
    .mem   (mif.master)
  );

  always #5 CLK = ~CLK;

  assign mif.D_out = mem[{mif.Y, mif.X}];

  always @(posedge CLK) begin
    if (RST && mif.WR) begin
      mem[{mif.Y, mif.X}] = 1'b1;
      wr_cnt = wr_cnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (mif.RD === 1'b1 && mif.WR === 1'b1) bus_err = bus_err + 1;
    if (mif.WR === 1'b1 && mif.D_in !== 1'b1) bus_err = bus_err + 1;
    if (^{mif.X, mif.Y} === 1'bx) bus_err = bus_err + 1;
  end

  task automatic do_reset();
    Start = 1'b0;
    Run   = 1'b0;
    RST   = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic wall(input int x, input int y);
    mem[y*16 + x] = 1'b1;
  endtask

  task automatic start_search();
    wr_cnt = 0;
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int cyc;
    cyc = 0;
    while (!(Done === 1'b1 || Fail === 1'b1) && cyc < 4000) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL %s: timeout, Done=%b Fail=%b after %0d cycles, required a result", name, Done, Fail, cyc);
    end
  endtask

  task automatic check_replay(input string name);
    @(negedge CLK);
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge CLK);
      checks++;
      if (Move !== exp_q[i] || Done !== 1'b1) begin
        errors++;
        $display("FAIL %s move[%0d]: Move=%b Done=%b, required Move=%b Done=1", name, i, Move, Done, exp_q[i]);
      end
    end
    @(negedge CLK);
    checks++;
    if (Move !== 2'b00 || Done !== 1'b1) begin
      errors++;
      $display("FAIL %s end: Move=%b Done=%b, required Move=00 Done=1", name, Move, Done);
    end
  endtask

  task automatic load_l_maze();
    mem = '0;
    for (int y = 1; y <= 14; y++) wall(14, y);
    exp_q.delete();
    for (int k = 0; k < 15; k++) exp_q.push_back(2'b01);
    for (int k = 0; k < 15; k++) exp_q.push_back(2'b11);
  endtask

  task automatic test_reset();
    mem = '0;
    do_reset();
    #1;
    checks++;
    if ({Done, Fail, Move, mif.RD, mif.WR, mif.D_in, mif.X, mif.Y} !== 15'd0) begin
      errors++;
      $display("FAIL reset: outputs=%h, required 0", {Done, Fail, Move, mif.RD, mif.WR, mif.D_in, mif.X, mif.Y});
    end
  endtask

  task automatic test_open_maze();
    mem = '0;
    exp_q.delete();
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 15; k++) exp_q.push_back((r % 2 == 0) ? 2'b01 : 2'b10);
      exp_q.push_back(2'b11);
    end
    do_reset();
    start_search();
    wait_result("open");
    checks++;
    if (Done !== 1'b1 || Fail !== 1'b0 || wr_cnt != 241) begin
      errors++;
      $display("FAIL open result: Done=%b Fail=%b writes=%0d, required 1 0 241", Done, Fail, wr_cnt);
    end
    check_replay("open");
  endtask

  task automatic test_blocked();
    mem = '0;
    wall(1, 0);
    wall(0, 1);
    do_reset();
    start_search();
    wait_result("blocked");
    checks++;
    if (Fail !== 1'b1 || Done !== 1'b0 || wr_cnt != 1) begin
      errors++;
      $display("FAIL blocked result: Fail=%b Done=%b writes=%0d, required 1 0 1", Fail, Done, wr_cnt);
    end
    @(negedge CLK);
    Run = 1'b1;
    Start = 1'b1;
    repeat (3) @(negedge CLK);
    Run = 1'b0;
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    checks++;
    if (Fail !== 1'b1 || Done !== 1'b0 || wr_cnt != 1 || Move !== 2'b00) begin
      errors++;
      $display("FAIL blocked terminal: Fail=%b Done=%b writes=%0d Move=%b, required 1 0 1 00", Fail, Done, wr_cnt, Move);
    end
  endtask

  task automatic test_dead_end();
    mem = '0;
    wall(3, 0);
    wall(2, 1);
    for (int y = 1; y <= 14; y++) wall(1, y);
    for (int x = 2; x <= 15; x++) wall(x, 14);
    exp_q.delete();
    for (int k = 0; k < 15; k++) exp_q.push_back(2'b11);
    for (int k = 0; k < 15; k++) exp_q.push_back(2'b01);
    do_reset();
    start_search();
    wait_result("dead_end");
    checks++;
    if (Done !== 1'b1 || Fail !== 1'b0 || wr_cnt != 33 || mem[2] !== 1'b1) begin
      errors++;
      $display("FAIL dead_end result: Done=%b Fail=%b writes=%0d visited(2,0)=%b, required 1 0 33 1", Done, Fail, wr_cnt, mem[2]);
    end
    check_replay("dead_end");
  endtask

  task automatic test_abort();
    mem = '0;
    do_reset();
    start_search();
    repeat (20) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({Done, Fail, Move, mif.RD, mif.WR, mif.X, mif.Y} !== 14'd0) begin
      errors++;
      $display("FAIL abort async: outputs=%h, required 0", {Done, Fail, Move, mif.RD, mif.WR, mif.X, mif.Y});
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({Done, Fail, mif.RD, mif.WR} !== 4'd0) begin
      errors++;
      $display("FAIL abort idle: Done/Fail/RD/WR=%b, required 0000", {Done, Fail, mif.RD, mif.WR});
    end
    load_l_maze();
    start_search();
    wait_result("abort_resolve");
    checks++;
    if (Done !== 1'b1 || Fail !== 1'b0 || wr_cnt != 31) begin
      errors++;
      $display("FAIL abort_resolve: Done=%b Fail=%b writes=%0d, required 1 0 31", Done, Fail, wr_cnt);
    end
    check_replay("abort_resolve");
  endtask

  task automatic test_back_to_back();
    load_l_maze();
    check_replay("replay1");
    repeat (35) @(negedge CLK);
    checks++;
    if (Done !== 1'b1 || Move !== 2'b00) begin
      errors++;
      $display("FAIL replay gap: Done=%b Move=%b, required 1 00", Done, Move);
    end
    check_replay("replay2");
  endtask

  task automatic test_bus();
    checks++;
    if (bus_err != 0) begin
      errors++;
      $display("FAIL bus: %0d protocol violations, required 0", bus_err);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    bus_err = 0;
    wr_cnt  = 0;
    mem     = '0;
    RST     = 1'b0;
    Start   = 1'b0;
    Run     = 1'b0;
    test_reset();
    test_open_maze();
    test_blocked();
    test_dead_end();
    test_abort();
    test_back_to_back();
    test_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
